// File: rtl/core_mmio_initiator.sv
// core_mmio_initiator
// Initiator end of the core's MMIO request/grant bus. Accepts one load/store
// command at a time, rejects misaligned or out-of-window addresses without
// touching the bus, otherwise raises mmio_req until granted, captures the
// responder's registered rdata/error one cycle after the grant and returns a
// response with a cause code. A grant timeout keeps a missing responder from
// hanging the core.
//
// Ports:
//   g_clk, g_reset              clock, synchronous active-high reset
//   cmd_valid/ready/wen/addr/wdata   command channel from the memory stage
//   rsp_valid/ready/rdata/cause      response channel (cause: 0 ok, 1 bus
//                                    error, 2 bad address, 3 timeout)
//   mmio_req/wen/addr/wdata     bus request outputs (registered)
//   mmio_gnt                    grant, honoured only while requesting
//   mmio_rdata/error            responder data/status, valid the cycle after grant
module core_mmio_initiator #(
    parameter int                    MEM_ADDR_W = 39,
    parameter int                    MEM_DATA_W = 64,
    parameter logic [MEM_ADDR_W-1:0] MMIO_BASE  = 39'h0,
    parameter logic [MEM_ADDR_W-1:0] MMIO_SIZE  = 39'h100,
    parameter int                    TIMEOUT    = 16
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wen,
    input  logic [MEM_ADDR_W-1:0] cmd_addr,
    input  logic [MEM_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MEM_DATA_W-1:0] rsp_rdata,
    output logic [1:0]            rsp_cause,
    output logic                  mmio_req,
    output logic                  mmio_wen,
    output logic [MEM_ADDR_W-1:0] mmio_addr,
    output logic [MEM_DATA_W-1:0] mmio_wdata,
    input  logic                  mmio_gnt,
    input  logic [MEM_DATA_W-1:0] mmio_rdata,
    input  logic                  mmio_error
);

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [MEM_ADDR_W:0] WIN_LO   = {1'b0, MMIO_BASE};
    localparam logic [MEM_ADDR_W:0] WIN_SIZE = {1'b0, MMIO_SIZE};

    localparam logic [1:0] CAUSE_OK      = 2'd0;
    localparam logic [1:0] CAUSE_BUS_ERR = 2'd1;
    localparam logic [1:0] CAUSE_BAD     = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;

    // Window check done as an offset from the base at one extra bit: an
    // address below the base makes the offset negative (top bit set), and
    // comparing the offset against the size avoids computing a window end
    // that could wrap.
    function automatic logic addr_bad(input logic [MEM_ADDR_W-1:0] a);
        logic [MEM_ADDR_W:0] off;
        off = {1'b0, a} - WIN_LO;
        return (a[2:0] != 3'b000) || off[MEM_ADDR_W] || (off >= WIN_SIZE);
    endfunction

    assign cmd_ready = (state == ST_IDLE) && !g_reset;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mmio_req   <= 1'b0;
            mmio_wen   <= 1'b0;
            mmio_addr  <= '0;
            mmio_wdata <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_cause  <= CAUSE_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (addr_bad(cmd_addr)) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_cause <= CAUSE_BAD;
                            state     <= ST_RESP;
                        end else begin
                            mmio_req   <= 1'b1;
                            mmio_wen   <= cmd_wen;
                            mmio_addr  <= cmd_addr;
                            mmio_wdata <= cmd_wdata;
                            cnt        <= '0;
                            state      <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // A grant on the last allowed cycle takes priority.
                    if (mmio_gnt) begin
                        mmio_req <= 1'b0;
                        state    <= ST_WAIT;
                    end else if (cnt == CNT_LAST) begin
                        mmio_req  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_cause <= CAUSE_TIMEOUT;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_cause <= mmio_error ? CAUSE_BUS_ERR : CAUSE_OK;
                    rsp_rdata <= (!mmio_wen && !mmio_error) ? mmio_rdata : '0;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mmio_initiator.sv
// Self-checking bench for core_mmio_initiator: a table of directed commands
// with hand-derived expectations, randomized commands checked against a
// transaction-level model, and a reset-during-request sequence.
module tb_core_mmio_initiator;

    localparam int          AW      = 39;
    localparam int          DW      = 64;
    localparam longint      BASE    = 0;
    localparam longint      SIZE    = 256;
    localparam int          TIMEOUT = 16;

    logic          g_clk = 1'b0;
    logic          g_reset;
    logic          cmd_valid, cmd_ready, cmd_wen;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_cause;
    logic          mmio_req, mmio_wen;
    logic [AW-1:0] mmio_addr;
    logic [DW-1:0] mmio_wdata;
    logic          mmio_gnt;
    logic [DW-1:0] mmio_rdata;
    logic          mmio_error;

    core_mmio_initiator #(
        .MEM_ADDR_W(AW), .MEM_DATA_W(DW),
        .MMIO_BASE(39'h0), .MMIO_SIZE(39'h100), .TIMEOUT(TIMEOUT)
    ) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wen(cmd_wen),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_cause(rsp_cause),
        .mmio_req(mmio_req), .mmio_wen(mmio_wen), .mmio_addr(mmio_addr),
        .mmio_wdata(mmio_wdata), .mmio_gnt(mmio_gnt),
        .mmio_rdata(mmio_rdata), .mmio_error(mmio_error)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gnt_d;   // index of the request cycle that gets the grant
        logic          err;     // responder error flag
        logic [DW-1:0] data;    // responder read data
        int            hold;    // cycles rsp_ready is held low
        logic [1:0]    cause;
        logic [DW-1:0] rdata;
        int            lat;     // accept edge to first rsp_valid, in cycles
        int            reqs;    // cycles mmio_req is high
    } vec_t;

    int checks = 0;
    int errors = 0;

    // responder state
    int            req_idx;
    int            gnt_d;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    bit            spur;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock; inputs are updated 1 time unit after the edge. The responder
    // returns its data/error only in the cycle after a granted request and
    // drives noise otherwise.
    task automatic step();
        logic fired;
        fired = mmio_req && mmio_gnt;
        @(posedge g_clk);
        #1;
        if (fired) begin
            mmio_rdata = resp_data;
            mmio_error = resp_err;
        end else begin
            mmio_rdata = {$urandom, $urandom};
            mmio_error = spur ? 1'($urandom) : 1'b0;
        end
        if (mmio_req) begin
            mmio_gnt = (req_idx == gnt_d);
            req_idx++;
        end else begin
            mmio_gnt = spur ? 1'($urandom) : 1'b0;
        end
    endtask

    // Transaction-level expectation from the address rules and grant timing.
    task automatic model(input vec_t v, output vec_t e);
        longint a;
        e = v;
        a = longint'(v.addr);
        if (v.addr[2:0] != 3'b000 || a < BASE || a >= BASE + SIZE) begin
            e.cause = 2'd2; e.rdata = '0; e.lat = 1; e.reqs = 0;
        end else if (v.gnt_d < TIMEOUT) begin
            e.cause = v.err ? 2'd1 : 2'd0;
            e.rdata = (!v.wen && !v.err) ? v.data : '0;
            e.lat   = v.gnt_d + 3;
            e.reqs  = v.gnt_d + 1;
        end else begin
            e.cause = 2'd3; e.rdata = '0; e.lat = TIMEOUT + 1; e.reqs = TIMEOUT;
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int            lat, reqs;
        bit            done;
        logic [AW-1:0] a0;
        logic [DW-1:0] w0, r0;
        logic          we0;
        logic [1:0]    c0;
        gnt_d = v.gnt_d; resp_data = v.data; resp_err = v.err; req_idx = 0;
        a0 = '0; w0 = '0; we0 = 1'b0;
        cmd_valid = 1'b1; cmd_wen = v.wen; cmd_addr = v.addr; cmd_wdata = v.wdata;
        chk({tag, " cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
        step();
        // scramble the command inputs so any late sampling is visible
        cmd_valid = 1'b0; cmd_wen = 1'($urandom);
        cmd_addr = AW'({$urandom, $urandom}); cmd_wdata = {$urandom, $urandom};
        lat = 1; reqs = 0; done = 0;
        while (!done && lat <= 60) begin
            if (mmio_req) begin
                if (reqs == 0) begin
                    a0 = mmio_addr; w0 = mmio_wdata; we0 = mmio_wen;
                end else if (mmio_addr !== a0 || mmio_wdata !== w0 || mmio_wen !== we0) begin
                    chk({tag, " bus_stable"}, 64'(mmio_addr), 64'(a0));
                end
                reqs++;
            end
            if (rsp_valid) done = 1;
            else begin
                step();
                lat++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s rsp_wait: got no rsp_valid within 60 cycles required %0d", tag, v.lat);
            return;
        end
        chk({tag, " latency"}, 64'(lat), 64'(v.lat));
        chk({tag, " req_cycles"}, 64'(reqs), 64'(v.reqs));
        chk({tag, " rdata"}, rsp_rdata, v.rdata);
        chk({tag, " cause"}, 64'(rsp_cause), 64'(v.cause));
        if (reqs > 0) begin
            chk({tag, " bus_addr"}, 64'(a0), 64'(v.addr));
            chk({tag, " bus_wdata"}, w0, v.wdata);
            chk({tag, " bus_wen"}, 64'(we0), 64'(v.wen));
        end
        r0 = rsp_rdata; c0 = rsp_cause;
        rsp_ready = 1'b0;
        for (int k = 0; k < v.hold; k++) begin
            chk({tag, " cmd_ready_busy"}, 64'(cmd_ready), 64'd0);
            step();
            chk({tag, " hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, " hold_rdata"}, rsp_rdata, r0);
            chk({tag, " hold_cause"}, 64'(rsp_cause), 64'(c0));
        end
        // consume, while offering a command that must not be taken this cycle
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_addr = 39'h4;
        chk({tag, " cmd_ready_consume"}, 64'(cmd_ready), 64'd0);
        step();
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        chk({tag, " rsp_dropped"}, 64'(rsp_valid), 64'd0);
        chk({tag, " no_accept_on_consume"}, 64'(mmio_req), 64'd0);
        chk({tag, " cmd_ready_after"}, 64'(cmd_ready), 64'd1);
    endtask

    vec_t tbl[11];

    initial begin
        vec_t v, e;
        g_reset = 1'b1; cmd_valid = 1'b0; cmd_wen = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; mmio_gnt = 1'b0; mmio_rdata = '0; mmio_error = 1'b0;
        req_idx = 0; gnt_d = 0; resp_data = '0; resp_err = 1'b0; spur = 0;

        //        wen  addr                 wdata            gd   err data         hold cause rdata         lat reqs
        tbl[0]  = '{1'b0, 39'h0,           64'h0,           0,   1'b0, 64'h1234, 0,   2'd0, 64'h1234, 3,  1};
        tbl[1]  = '{1'b1, 39'h8,           64'hFFFF_0000,   3,   1'b0, 64'hDEAD, 0,   2'd0, 64'h0,    6,  4};
        tbl[2]  = '{1'b0, 39'h4,           64'h0,           0,   1'b0, 64'h99,   0,   2'd2, 64'h0,    1,  0};
        tbl[3]  = '{1'b0, 39'h100,         64'h0,           0,   1'b0, 64'h99,   0,   2'd2, 64'h0,    1,  0};
        tbl[4]  = '{1'b0, 39'h0,           64'h0,           100, 1'b0, 64'h5,    0,   2'd3, 64'h0,    17, 16};
        tbl[5]  = '{1'b0, 39'h10,          64'h0,           15,  1'b0, 64'hAA,   0,   2'd0, 64'hAA,   18, 16};
        tbl[6]  = '{1'b0, 39'h20,          64'h0,           1,   1'b1, 64'h55,   5,   2'd1, 64'h0,    4,  2};
        tbl[7]  = '{1'b0, 39'hF8,          64'h0,           0,   1'b0, 64'h77,   2,   2'd0, 64'h77,   3,  1};
        tbl[8]  = '{1'b1, 39'hF8,          64'h1111,        2,   1'b1, 64'h3,    0,   2'd1, 64'h0,    5,  3};
        tbl[9]  = '{1'b0, 39'h7F_FFFF_FFF8, 64'h0,          0,   1'b0, 64'h1,    0,   2'd2, 64'h0,    1,  0};
        tbl[10] = '{1'b0, 39'hFF,          64'h0,           0,   1'b0, 64'h1,    1,   2'd2, 64'h0,    1,  0};

        // reset state
        step(); step();
        chk("rst mmio_req", 64'(mmio_req), 64'd0);
        chk("rst mmio_wen", 64'(mmio_wen), 64'd0);
        chk("rst mmio_addr", 64'(mmio_addr), 64'd0);
        chk("rst mmio_wdata", mmio_wdata, 64'd0);
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst rsp_rdata", rsp_rdata, 64'd0);
        chk("rst rsp_cause", 64'(rsp_cause), 64'd0);
        chk("rst cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
        g_reset = 1'b0;
        #1;
        chk("rst cmd_ready_released", 64'(cmd_ready), 64'd1);

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // reset while requesting, with the grant present in the same cycle
        gnt_d = 1; resp_err = 1'b1; resp_data = 64'hBAD; req_idx = 0;
        cmd_valid = 1'b1; cmd_wen = 1'b0; cmd_addr = 39'h40; cmd_wdata = '0;
        step();
        cmd_valid = 1'b0;
        step();
        chk("mid_rst req_before", 64'(mmio_req), 64'd1);
        chk("mid_rst gnt_before", 64'(mmio_gnt), 64'd1);
        g_reset = 1'b1;
        step();
        chk("mid_rst req_after", 64'(mmio_req), 64'd0);
        chk("mid_rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
        g_reset = 1'b0;
        #1;
        chk("mid_rst cmd_ready", 64'(cmd_ready), 64'd1);
        spur = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mid_rst quiet_rsp", 64'(rsp_valid), 64'd0);
            chk("mid_rst quiet_req", 64'(mmio_req), 64'd0);
        end
        spur = 0;
        mmio_gnt = 1'b0;
        run(tbl[0], "post_rst");

        // randomized commands against the model; spurious grants outside REQ
        for (int n = 0; n < 150; n++) begin
            spur = 1;
            v.wen   = 1'($urandom);
            case ($urandom_range(0, 3))
                0, 1: v.addr = AW'({$urandom_range(0, 31), 3'b000});
                2:    v.addr = AW'({$urandom_range(0, 31), 3'($urandom_range(1, 7))});
                default: v.addr = AW'(39'h100 + AW'({$urandom_range(0, 1000), 3'b000}));
            endcase
            v.wdata = {$urandom, $urandom};
            v.gnt_d = $urandom_range(0, 18);
            v.err   = ($urandom_range(0, 3) == 0);
            v.data  = {$urandom, $urandom};
            v.hold  = $urandom_range(0, 3);
            model(v, e);
            // keep the responder from granting early through noise
            run(e, $sformatf("rnd%0d", n));
            spur = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_mmio_initiator.md
Name: core_mmio_initiator

Overview:
Initiator end of the core's MMIO request/grant bus. It takes single load/store commands from the core's memory stage, range- and alignment-checks them, and drives mmio_req/wen/addr/wdata until granted. It then captures the registered mmio_rdata/mmio_error one cycle later and returns a response with a cause code. It drives peripherals such as the timer/counter block, and a grant timeout stops a missing responder from hanging the core.

Parameters:
MEM_ADDR_W, 39, MMIO address width
MEM_DATA_W, 64, MMIO data width
MMIO_BASE, 39'h0, lowest legal MMIO address
MMIO_SIZE, 39'h100, size in bytes of the legal MMIO window
TIMEOUT, 16, max cycles mmio_req may wait for mmio_gnt (>=2)

Ports:
g_clk  in  1  global clock
g_reset  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&&ready
cmd_wen  in  1  1=write, 0=read
cmd_addr  in  MEM_ADDR_W  byte address
cmd_wdata  in  MEM_DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&&ready
rsp_rdata  out  MEM_DATA_W  read data (0 for writes and errors)
rsp_cause  out  2  0=ok, 1=bus error, 2=bad address, 3=timeout
mmio_req  out  1  bus request
mmio_wen  out  1  bus write enable
mmio_addr  out  MEM_ADDR_W  bus address
mmio_wdata  out  MEM_DATA_W  bus write data
mmio_gnt  in  1  request granted this cycle
mmio_rdata  in  MEM_DATA_W  read data, valid the cycle after grant
mmio_error  in  1  error, valid the cycle after grant

Behaviour:
- One clock, g_clk. Reset is synchronous, active-high on g_reset.
- Reset behaviour: at the edge with g_reset=1, state=IDLE and all registered outputs clear: mmio_req/wen/addr/wdata=0, rsp_valid=0, rsp_rdata=0, rsp_cause=0, timeout counter=0.
- cmd_ready = (state==IDLE) && !g_reset. It is combinational from state only, never from cmd_valid.
- FSM states:
  - IDLE: on cmd_valid, latch wen/addr/wdata.
    - bad = addr[2:0]!=0, or addr<MMIO_BASE, or addr>=MMIO_BASE+MMIO_SIZE. Compare at MEM_ADDR_W+1 bits so the window end cannot wrap.
    - bad -> RESP with cause=2, rdata=0. The bus is never touched.
    - otherwise -> REQ. mmio_req=1 from the next cycle.
  - REQ: mmio_req=1; wen/addr/wdata held stable from registers.
    - mmio_gnt=1 -> WAIT. mmio_req drops the next cycle.
    - mmio_gnt=0: counter increments. If the counter ==TIMEOUT-1 and gnt=0 -> RESP with cause=3, rdata=0, mmio_req=0 next cycle.
    - Grant on the final cycle wins over timeout.
  - WAIT (exactly 1 cycle, mmio_req=0): sample mmio_error and mmio_rdata.
    - cause = mmio_error ? 1 : 0.
    - rdata = (!wen && !mmio_error) ? mmio_rdata : 0.
    - -> RESP.
  - RESP: rsp_valid=1; rsp_rdata/rsp_cause held stable until rsp_ready. On rsp_valid&&rsp_ready -> IDLE, and rsp_valid=0 next cycle.
- The timeout counter clears on entry to REQ. Its width is clog2(TIMEOUT).
- Only one command is outstanding at a time; no pipelining.
- Minimum latency, cmd accept to rsp_valid:
  - granted access: 3 cycles (gnt on first REQ cycle).
  - bad-address access: 1 cycle.
- No new command is accepted in the cycle a response is consumed. The earliest next accept is the following cycle.
- Reset mid-operation: reset in any state aborts it. mmio_req is 0 the cycle after the reset edge, no response is produced for the aborted command, and a late mmio_gnt/mmio_error is ignored.
- mmio_gnt while not in REQ is ignored.

Test Plan:
- Read, responder always granting with rdata=64'h1234 one cycle after grant: cmd read addr=0 -> mmio_req high 1 cycle, rsp_valid 3 cycles after accept, rsp_rdata=64'h1234, cause=0.
- Write addr=8, wdata=64'hFFFF_0000, gnt delayed 3 cycles -> mmio_addr/wdata stable for all 4 req cycles, mmio_wen=1, rsp_rdata=0, cause=0.
- Misaligned addr=0x4, and out-of-range addr=0x100 -> no mmio_req ever, rsp_valid 1 cycle after accept, cause=2.
- Responder never grants, TIMEOUT=16 -> mmio_req high exactly 16 cycles, then cause=3. Separate run with grant on the 16th cycle -> normal completion, cause=0.
- Responder returns mmio_error=1 for a read -> cause=1, rdata=0. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata/cause stable and cmd_ready=0 throughout.
- Assert g_reset during REQ with gnt arriving the same cycle -> next cycle mmio_req=0, rsp_valid=0, cmd_ready=1 after reset deasserts.
